// File: rtl/reg_load_arb.sv
// reg_load_arb: round-robin arbiter that lets NREQ requesters share one
// register bank. A granted requester gets exactly one bank operation
// (load via ce=0 with d, clear via r, or set via s) and then a one-cycle ack.
//
// Request levels are registered once before IDLE looks at them. That input
// stage sets the req->ack latency to four cycles. The winner is chosen from
// the live req levels in ARB, so a requester that has already withdrawn is
// never granted.
//
// Optional feature: define REG_LOAD_ARB_READBACK_EN to compare the bank
// readback q against the expected contents during ACK. A mismatch sets a
// sticky err flag. When the macro is undefined, err is tied to 0 and q is
// ignored.
module reg_load_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [WIDTH-1:0]      d,
  output logic                  ce,
  output logic                  r,
  output logic                  s,
  input  logic [WIDTH-1:0]      q,
  output logic                  err
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0]      NREQ_W   = (IW+1)'(NREQ);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE      = NREQ'(1);
  localparam logic [1:0]       OP_CLEAR = 2'b01;
  localparam logic [1:0]       OP_SET   = 2'b10;

  typedef enum logic [1:0] {IDLE, ARB, LOAD, ACK} state_e;

  state_e            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     win_q;
  logic [NREQ-1:0]   req_q;
  logic [NREQ-1:0]   ack_q;
  logic              busy_q;
  logic [WIDTH-1:0]  d_q;
  logic              ce_q;
  logic              r_q;
  logic              s_q;

  logic              found_d;
  logic [IW-1:0]     win_d;
  logic [1:0]        op_d;
  logic [WIDTH-1:0]  data_d;
  logic [IW:0]       cand_sum;
  logic [IW-1:0]     cand;

  // Round-robin search starting at the pointer; selects the winner's op and data
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    found_d  = 1'b0;
    win_d    = '0;
    op_d     = 2'b00;
    data_d   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand_sum >= NREQ_W) begin
        cand_sum = cand_sum - NREQ_W;
      end
      cand = cand_sum[IW-1:0];
      if (!found_d && req[cand]) begin
        found_d = 1'b1;
        win_d   = cand;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (IW'(j) == win_d) begin
        op_d   = op[2*j +: 2];
        data_d = din[WIDTH*j +: WIDTH];
      end
    end
  end

  // Control FSM: outputs are registered and change together with the state
  // NOTE: state and output registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      req_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      d_q     <= '0;
      ce_q    <= 1'b1;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      // Strobes and ack last one cycle unless a state sets them again.
      ack_q <= '0;
      ce_q  <= 1'b1;
      r_q   <= 1'b0;
      s_q   <= 1'b0;
      req_q <= req;
      case (state_q)
        IDLE: begin
          if (|req_q) begin
            state_q <= ARB;
            busy_q  <= 1'b1;
          end
        end
        ARB: begin
          if (found_d) begin
            state_q <= LOAD;
            win_q   <= win_d;
            d_q     <= data_d;
            case (op_d)
              OP_CLEAR: r_q  <= 1'b1;
              OP_SET:   s_q  <= 1'b1;
              default:  ce_q <= 1'b0;
            endcase
          end else begin
            // Every requester withdrew: no grant, no strobe.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        LOAD: begin
          state_q <= ACK;
          ack_q   <= ONE << win_q;
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
          // The requester just served may still hold req this cycle.
          // Mask it so it is not seen as a new request.
          req_q   <= req & ~(ONE << win_q);
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack  = ack_q;
  assign busy = busy_q;
  assign d    = d_q;
  assign ce   = ce_q;
  assign r    = r_q;
  assign s    = s_q;

`ifdef REG_LOAD_ARB_READBACK_EN
  logic [1:0]       op_q;
  logic             err_q;
  logic [WIDTH-1:0] rb_exp;

  // Expected bank contents after the latched operation
  always_comb begin
    rb_exp = d_q;
    case (op_q)
      OP_CLEAR: rb_exp = '0;
      OP_SET:   rb_exp = '1;
      default:  rb_exp = d_q;
    endcase
  end

  // Latch the granted op and keep a sticky readback-mismatch flag
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= 2'b00;
      err_q <= 1'b0;
    end else begin
      if (state_q == ARB && found_d) begin
        op_q <= op_d;
      end
      if (state_q == ACK && q != rb_exp) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_readback;
  assign unused_readback = ^q;
  assign err = 1'b0;
`endif

endmodule
